latency_meter_mc: RTL and testbench



---
 rtl/latency_meter_mc_if.sv | 10 +
 rtl/latency_meter_mc.sv | 157 +++++++++++++++
 tb/tb_latency_meter_mc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/latency_meter_mc_if.sv
// rtl/latency_meter_mc_if.sv - video output bundle toward the HDMI/DVI transmitter
interface latency_meter_mc_if;
    logic [23:0] data_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;

    modport master (output data_out, hsync_out, vsync_out, de_out);
    modport slave  (input  data_out, hsync_out, vsync_out, de_out);
endinterface

// File: rtl/latency_meter_mc.sv
// rtl/latency_meter_mc.sv - raster generator with white-flash latency timing on NUM_CH photo-sensors
module latency_meter_mc #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 1125,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 32'd148500000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_in,
    input  logic                clear_in,
    input  logic [NUM_CH-1:0]   sensor_n_in,
    input  logic [NUM_CH-1:0]   ch_mask_in,
    input  logic [2:0]          sw,
    input  logic [2:0]          lat_sel_in,
    latency_meter_mc_if.master  vid,
    output logic [CNT_W-1:0]    lat_out,
    output logic [NUM_CH-1:0]   ch_done_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                timeout_out
);
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam logic [HW-1:0]    H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_LAST = VW'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_FLASH, S_DONE, S_TO} state_t;

    state_t              r_state;
    logic [HW-1:0]       r_cx;
    logic [VW-1:0]       r_cy;
    logic [NUM_CH-1:0]   r_s1, r_s2;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_ch_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_lat [NUM_CH];
    logic [CNT_W-1:0]    r_lat_out;
    logic                r_busy, r_done, r_to;

    logic                w_de, w_hs, w_vs, w_frame_start, w_all_done;
    logic [NUM_CH-1:0]   w_hit;
    logic [CNT_W-1:0]    w_lat_sel;

    assign w_de = (32'(r_cx) < H_ACTIVE) && (32'(r_cy) < V_ACTIVE);
    assign w_hs = (32'(r_cx) >= H_ACTIVE + H_FP) && (32'(r_cx) < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs = (32'(r_cy) >= V_ACTIVE + V_FP) && (32'(r_cy) < V_ACTIVE + V_FP + V_SYNC);
    assign w_frame_start = (r_cx == '0) && (r_cy == '0);

    // Channels latching this cycle count toward completion, so the last latch and timeout resolve to DONE.
    assign w_hit      = r_mask & ~r_ch_done & ~r_s2;
    assign w_all_done = ((r_ch_done | w_hit) & r_mask) == r_mask;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_cx == H_LAST) begin
            r_cx <= '0;
            r_cy <= (r_cy == V_LAST) ? '0 : r_cy + 1'b1;
        end else begin
            r_cx <= r_cx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vid.de_out    <= 1'b0;
            vid.hsync_out <= ~SYNC_POL;
            vid.vsync_out <= ~SYNC_POL;
            vid.data_out  <= '0;
        end else begin
            vid.de_out    <= w_de;
            vid.hsync_out <= w_hs ? SYNC_POL : ~SYNC_POL;
            vid.vsync_out <= w_vs ? SYNC_POL : ~SYNC_POL;
            vid.data_out  <= (r_state == S_FLASH) ? 24'hFFFFFF
                                                  : {{8{sw[2]}}, {8{sw[1]}}, {8{sw[0]}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= sensor_n_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clear_in) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_ch_done <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_to      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_lat[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_in && (ch_mask_in != '0)) begin
                    r_mask  <= ch_mask_in;
                    r_state <= S_ARMED;
                    r_busy  <= 1'b1;
                end
                S_ARMED: if (w_frame_start) begin
                    r_state <= S_FLASH;
                    r_cnt   <= '0;
                end
                S_FLASH: begin
                    r_cnt     <= r_cnt + 1'b1;
                    r_ch_done <= r_ch_done | w_hit;
                    for (int i = 0; i < NUM_CH; i++)
                        if (w_hit[i]) r_lat[i] <= r_cnt;
                    if (w_all_done) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_TO;
                        r_busy  <= 1'b0;
                        r_to    <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_comb begin
        w_lat_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (lat_sel_in == 3'(i)) w_lat_sel = r_lat[i];
    end

    always_ff @(posedge CLK) begin
        if (RST) r_lat_out <= '0;
        else     r_lat_out <= w_lat_sel;
    end

    assign lat_out     = r_lat_out;
    assign ch_done_out = r_ch_done;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign timeout_out = r_to;
endmodule

// File: tb/tb_latency_meter_mc.sv
// tb/tb_latency_meter_mc.sv - self-checking bench for latency_meter_mc in a small video mode
module tb_latency_meter_mc;
    localparam int HA = 8, HFP = 2, HS = 2, HT = 16;
    localparam int VA = 4, VFP = 1, VS = 1, VT = 8;
    localparam int NCH = 4, TO_C = 500, FRAME = HT * VT;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [3:0]  sensor_n_in = 4'hF;
    logic [3:0]  ch_mask_in = 4'h0;
    logic [2:0]  sw = 3'b000;
    logic [2:0]  lat_sel_in = 3'd0;
    logic [31:0] lat_out;
    logic [3:0]  ch_done_out;
    logic        busy_out, done_out, timeout_out;

    latency_meter_mc_if vid_if();

    latency_meter_mc #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT),
        .SYNC_POL(1'b1), .NUM_CH(NCH), .CNT_W(32), .TIMEOUT(TO_C)
    ) dut (
        .CLK(CLK), .RST(RST), .start_in(start_in), .clear_in(clear_in),
        .sensor_n_in(sensor_n_in), .ch_mask_in(ch_mask_in), .sw(sw),
        .lat_sel_in(lat_sel_in), .vid(vid_if), .lat_out(lat_out),
        .ch_done_out(ch_done_out), .busy_out(busy_out), .done_out(done_out),
        .timeout_out(timeout_out)
    );

    always #5 CLK = ~CLK;

    // cyc = number of clocks since the last reset edge, i.e. cx + HT*cy of the current cycle modulo FRAME
    int cyc = 0;
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    int nchk = 0;
    int nerr = 0;
    int g_dly [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [23:0] col(input logic [2:0] s);
        return {{8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // One full run: start in raster slot, play sensors per g_dly (-1 = never), check every cycle, read back, clear.
    task automatic measure(input logic [3:0] mask, input int slot);
        int s, F, endc, D, n;
        bit all;
        int L [4];
        logic [6:0] exp_v;
        bit white;
        int sels [5];
        sels = '{0, 1, 2, 3, 5};
        for (int k = 0; k < FRAME && (cyc % FRAME) != slot; k++) tick();
        chk("start_slot", 64'(cyc % FRAME), 64'(slot));
        start_in = 1'b1;
        ch_mask_in = mask;
        s = cyc;
        tick();
        start_in = 1'b0;
        ch_mask_in = 4'($urandom);
        F = ((s + 1 + FRAME - 1) / FRAME) * FRAME + 1;
        all = 1'b1;
        D = 0;
        for (int i = 0; i < NCH; i++) begin
            L[i] = -1;
            if (mask[i]) begin
                if (g_dly[i] >= 0 && g_dly[i] + 2 <= TO_C - 1) begin
                    L[i] = F + g_dly[i] + 2;
                    if (L[i] > D) D = L[i];
                end else begin
                    all = 1'b0;
                end
            end
        end
        endc = all ? D + 1 : F + TO_C;
        while (cyc <= endc + 2) begin
            n = cyc;
            for (int i = 0; i < NCH; i++)
                sensor_n_in[i] = !(g_dly[i] >= 0 && n >= F + g_dly[i]);
            exp_v[6] = (n >= s + 1) && (n <= endc - 1);
            exp_v[5] = all && (n >= endc);
            exp_v[4] = !all && (n >= endc);
            for (int i = 0; i < NCH; i++) exp_v[i] = (L[i] >= 0) && (n >= L[i] + 1);
            chk("run_flags", 64'({busy_out, done_out, timeout_out, ch_done_out}), 64'(exp_v));
            white = (n >= F + 1) && (n <= endc);
            chk("run_data", 64'(vid_if.data_out), 64'(white ? 24'hFFFFFF : col(sw)));
            tick();
        end
        sensor_n_in = 4'hF;
        for (int j = 0; j < 5; j++) begin
            lat_sel_in = 3'(sels[j]);
            tick();
            chk("readback", 64'(lat_out),
                64'((sels[j] < NCH && L[sels[j] % NCH] >= 0) ? g_dly[sels[j] % NCH] + 2 : 0));
        end
        chk("hold", 64'({done_out, timeout_out}), 64'({all, !all}));
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("clr_flags", 64'({busy_out, done_out, timeout_out, ch_done_out}), 64'(0));
        lat_sel_in = 3'd0;
        tick();
        chk("clr_lat", 64'(lat_out), 64'(0));
    endtask

    initial begin
        int p, cx, cy, F, s;
        int de_cnt [2];
        sw = 3'b101;
        repeat (3) tick();
        chk("rst_video", 64'({vid_if.data_out, vid_if.de_out, vid_if.hsync_out, vid_if.vsync_out}), 64'(0));
        chk("rst_ctrl", 64'({lat_out, ch_done_out, busy_out, done_out, timeout_out}), 64'(0));
        RST = 1'b0;

        de_cnt = '{0, 0};
        while (cyc <= 2 * FRAME) begin
            if (cyc >= 1) begin
                p  = cyc - 1;
                cx = p % HT;
                cy = (p / HT) % VT;
                chk("raster", 64'({vid_if.de_out, vid_if.hsync_out, vid_if.vsync_out, vid_if.data_out}),
                    64'({(cx < HA && cy < VA), (cx >= 10 && cx < 12), (cy == 5), col(sw)}));
                if (vid_if.de_out) de_cnt[p / FRAME]++;
            end
            tick();
        end
        chk("de_frame0", 64'(de_cnt[0]), 64'(32));
        chk("de_frame1", 64'(de_cnt[1]), 64'(32));

        sw = 3'b010;
        g_dly = '{40, -1, -1, -1};
        measure(4'b0001, 5 + 2 * HT);
        g_dly = '{10, 30, 5, 60};
        measure(4'b1011, 77);
        g_dly = '{20, -1, -1, -1};
        measure(4'b0011, 100);
        sw = 3'b111;
        g_dly = '{497, -1, -1, -1};
        measure(4'b0001, 3);
        g_dly = '{498, -1, -1, -1};
        measure(4'b0001, 3);

        // clear coinciding with start and a synced sensor edge
        for (int k = 0; k < FRAME && (cyc % FRAME) != 3; k++) tick();
        start_in = 1'b1;
        ch_mask_in = 4'b0001;
        s = cyc;
        tick();
        start_in = 1'b0;
        F = ((s + 1 + FRAME - 1) / FRAME) * FRAME + 1;
        for (int k = 0; k < 2 * FRAME && cyc < F + 10; k++) tick();
        sensor_n_in[0] = 1'b0;
        tick();
        tick();
        chk("pre_clear_busy", 64'(busy_out), 64'(1));
        clear_in = 1'b1;
        start_in = 1'b1;
        tick();
        clear_in = 1'b0;
        start_in = 1'b0;
        chk("clr_prio_flags", 64'({busy_out, done_out, timeout_out, ch_done_out}), 64'(0));
        lat_sel_in = 3'd0;
        tick();
        chk("clr_prio_lat", 64'(lat_out), 64'(0));
        repeat (3) tick();
        chk("clr_stays_idle", 64'({busy_out, ch_done_out}), 64'(0));
        sensor_n_in = 4'hF;

        // reset in the middle of a run
        start_in = 1'b1;
        ch_mask_in = 4'b0110;
        tick();
        start_in = 1'b0;
        repeat (FRAME + 10) tick();
        RST = 1'b1;
        tick();
        chk("rst_mid", 64'({busy_out, done_out, timeout_out, ch_done_out, vid_if.de_out, vid_if.data_out}), 64'(0));
        RST = 1'b0;
        tick();

        for (int r = 0; r < 4; r++) begin
            sw = 3'($urandom);
            for (int i = 0; i < NCH; i++)
                g_dly[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 560));
            measure(4'($urandom_range(1, 15)), int'($urandom_range(0, FRAME - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
